load_store_unit: RTL

// - Initiator side of the core<->DataMemory interface. Sits between the ALU/ControlUnit and the data memory.
// - Accepts one load/store from the core and issues an aligned bus request with byte strobes.
// - Waits for the memory response. For loads, returns data that is byte-extracted and sign- or zero-extended.
// - Flags misaligned or illegal accesses without touching memory.

---
 rtl/load_store_unit_pkg.sv | 33 +++
 rtl/lsu_load_align.sv | 38 +++
 rtl/load_store_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access size codes
// and the natural-alignment check.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT_RSP,
    LSU_DONE,
    LSU_ERR
  } Lsu_State_t;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_D  = 3'b011,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101,
    MEM_WU = 3'b110
  } Mem_Size_t;

  // funct3[1:0] encodes log2 of the access size in bytes.
  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] a_lo);
    case (f3[1:0])
      2'b01:   return a_lo[0];
      2'b10:   return |a_lo[1:0];
      2'b11:   return |a_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: pulls the addressed bytes down to bit 0 of the word and
// sign- or zero-extends them to the full register width.
module lsu_load_align
  import load_store_unit_pkg::*;
#(
  parameter  int REG_DATA_WIDTH_POW = 6,
  localparam int XLEN   = 1 << REG_DATA_WIDTH_POW,
  localparam int LANE_W = REG_DATA_WIDTH_POW - 3
) (
  input  logic [XLEN-1:0]   rdata,
  input  logic [LANE_W-1:0] lane,
  input  logic [2:0]        funct3,
  output logic [XLEN-1:0]   data
);

  localparam logic [REG_DATA_WIDTH_POW-1:0] SH_B = REG_DATA_WIDTH_POW'(XLEN - 8);
  localparam logic [REG_DATA_WIDTH_POW-1:0] SH_H = REG_DATA_WIDTH_POW'(XLEN - 16);
  localparam logic [REG_DATA_WIDTH_POW-1:0] SH_W = REG_DATA_WIDTH_POW'(XLEN - 32);

  logic [XLEN-1:0]               shifted;
  logic signed [XLEN-1:0]        msb_aligned;
  logic [REG_DATA_WIDTH_POW-1:0] shamt;

  // Push the field up to the MSB, then shift back down: arithmetic for signed
  // loads, logical for unsigned ones. Works for any XLEN without replication.
  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    case (funct3[1:0])
      2'b00:   shamt = SH_B;
      2'b01:   shamt = SH_H;
      2'b10:   shamt = SH_W;
      default: shamt = '0;
    endcase
    msb_aligned = shifted << shamt;
    data = funct3[2] ? (msb_aligned >> shamt) : (msb_aligned >>> shamt);
  end

endmodule

// File: rtl/load_store_unit.sv
// Core-side load/store unit: one outstanding access, aligned bus request with byte
// strobes, and load data extraction on the response.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter  int REG_DATA_WIDTH_POW = 6,
  parameter  int ADDR_WIDTH         = 64,
  localparam int XLEN   = 1 << REG_DATA_WIDTH_POW,
  localparam int STRB_W = XLEN / 8,
  localparam int LANE_W = REG_DATA_WIDTH_POW - 3
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  lsu_valid_in,
  output logic                  lsu_ready_out,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [2:0]            funct3_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [XLEN-1:0]       store_data_in,
  output logic [XLEN-1:0]       load_data_out,
  output logic                  done_out,
  output logic                  error_out,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [XLEN-1:0]       mem_req_wdata,
  output logic [STRB_W-1:0]     mem_req_wstrb,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rsp_rdata
);

  function automatic logic [STRB_W-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return STRB_W'(1);
      2'b01:   return STRB_W'(3);
      2'b10:   return STRB_W'(15);
      default: return {STRB_W{1'b1}};
    endcase
  endfunction

  Lsu_State_t            state, state_nxt;
  logic                  req_we;
  logic [2:0]            req_f3;
  logic [LANE_W-1:0]     req_lane;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [XLEN-1:0]       req_wdata;
  logic [STRB_W-1:0]     req_wstrb;
  logic [XLEN-1:0]       load_data_q;
  logic [XLEN-1:0]       aligned;
  logic [LANE_W-1:0]     in_lane;
  logic                  illegal, bad_req;

  assign in_lane = addr_in[LANE_W-1:0];
  assign illegal = (funct3_in == 3'b111) ||
                   ((REG_DATA_WIDTH_POW == 5) && (funct3_in == MEM_D || funct3_in == MEM_WU));
  assign bad_req = !(mem_read_in ^ mem_write_in) || illegal || misaligned(funct3_in, addr_in[2:0]);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) state <= LSU_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE:     if (lsu_valid_in) state_nxt = bad_req ? LSU_ERR : LSU_REQ;
      LSU_REQ:      if (mem_req_ready) state_nxt = LSU_WAIT_RSP;
      LSU_WAIT_RSP: if (mem_rsp_valid) state_nxt = LSU_DONE;
      default:      state_nxt = LSU_IDLE;
    endcase
  end

  always_comb begin
    lsu_ready_out = (state == LSU_IDLE);
    mem_req_valid = (state == LSU_REQ);
    done_out      = (state == LSU_DONE);
    error_out     = (state == LSU_ERR);
  end

  // Request is captured pre-shifted so the bus side is a plain register read-out.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      req_we      <= 1'b0;
      req_f3      <= '0;
      req_lane    <= '0;
      req_addr    <= '0;
      req_wdata   <= '0;
      req_wstrb   <= '0;
      load_data_q <= '0;
    end else begin
      if (state == LSU_IDLE && lsu_valid_in && !bad_req) begin
        req_we    <= mem_write_in;
        req_f3    <= funct3_in;
        req_lane  <= in_lane;
        req_addr  <= {addr_in[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
        req_wstrb <= mem_write_in ? (size_mask(funct3_in[1:0]) << in_lane) : '0;
        req_wdata <= mem_write_in ? (store_data_in << {in_lane, 3'b000}) : '0;
      end
      if (state == LSU_WAIT_RSP && mem_rsp_valid)
        load_data_q <= req_we ? '0 : aligned;
    end
  end

  lsu_load_align #(
    .REG_DATA_WIDTH_POW(REG_DATA_WIDTH_POW)
  ) u_align (
    .rdata  (mem_rsp_rdata),
    .lane   (req_lane),
    .funct3 (req_f3),
    .data   (aligned)
  );

  assign mem_req_we    = mem_req_valid & req_we;
  assign mem_req_addr  = mem_req_valid ? req_addr  : '0;
  assign mem_req_wdata = mem_req_valid ? req_wdata : '0;
  assign mem_req_wstrb = mem_req_valid ? req_wstrb : '0;
  assign load_data_out = load_data_q;

endmodule
